// File: rtl/fifo_readback_checker.sv
// fifo_readback_checker
// Reads a burst of bytes from the debug FIFO and checks it against an
// incrementing pattern. Mismatches are counted, and the first mismatch is
// captured. When the burst ends, or when the FIFO stays empty too long, the
// block reports pass/fail on a set of registered probe outputs.
module fifo_readback_checker #(
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       BURST_LEN      = 256,
    parameter logic [DATA_W-1:0] START_VALUE    = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [15:0]       rd_count,
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int unsigned       TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]       BURST_CNT = 16'(BURST_LEN);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_REPORT
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       issued_q, issued_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic [15:0]       first_idx_q, first_idx_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    // A read is requested only when data is present and the burst is not
    // fully issued. Reset gates it at once so the FIFO sees no read in the
    // reset cycle.
    assign fifo_rd_en = (state_q == S_READ) && !fifo_empty &&
                        (issued_q < BURST_CNT) && !srst;
    // busy also drops in the reset cycle itself, so it agrees with fifo_rd_en.
    assign busy       = (state_q != S_IDLE) && !srst;

    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign rd_count       = rd_count_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_data = first_data_q;

    // Next-state logic, the one-cycle compare pipeline, and result bookkeeping.
    always_comb begin
        // NOTE: every variable gets its default first, so no path can infer a latch.
        state_d      = state_q;
        issued_d     = issued_q;
        timer_d      = timer_q;
        valid_d      = fifo_rd_en;
        expected_d   = expected_q;
        err_count_d  = err_count_q;
        rd_count_d   = rd_count_q;
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        done         = 1'b0;

        // The data from last cycle's read is on fifo_dout now.
        if (valid_q) begin
            rd_count_d = rd_count_q + 16'd1;
            expected_d = expected_q + DATA_ONE;
            if (fifo_dout != expected_q) begin
                if (err_count_q == 16'd0) begin
                    first_idx_d  = rd_count_q;
                    first_data_d = fifo_dout;
                end
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_READ;
                    issued_d     = '0;
                    timer_d      = '0;
                    expected_d   = START_VALUE;
                    err_count_d  = '0;
                    rd_count_d   = '0;
                    first_idx_d  = '0;
                    first_data_d = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            S_READ: begin
                if (fifo_rd_en) begin
                    issued_d = issued_q + 16'd1;
                    timer_d  = '0;
                    // Leave READ in the same cycle as the last read, so that
                    // done lands exactly BURST_LEN+2 cycles after start.
                    if (issued_q + 16'd1 == BURST_CNT) begin
                        state_d = S_DRAIN;
                    end
                end else if (fifo_empty && (issued_q < BURST_CNT)) begin
                    timer_d = timer_q + TMO_W'(1);
                    if (timer_q + TMO_W'(1) == TMO_LIMIT) begin
                        state_d   = S_REPORT;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_REPORT;
            end
            S_REPORT: begin
                done    = 1'b1;
                state_d = S_IDLE;
                pass_d  = (err_count_q == 16'd0) && !timeout_q &&
                          (rd_count_q == BURST_CNT);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values.
        if (srst) begin
            state_q      <= S_IDLE;
            issued_q     <= '0;
            timer_q      <= '0;
            valid_q      <= 1'b0;
            expected_q   <= START_VALUE;
            err_count_q  <= '0;
            rd_count_q   <= '0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            timer_q      <= timer_d;
            valid_q      <= valid_d;
            expected_q   <= expected_d;
            err_count_q  <= err_count_d;
            rd_count_q   <= rd_count_d;
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fifo_readback_checker.sv
// Testbench for fifo_readback_checker. A queue-based FIFO model feeds the DUT
// from either a preload or a paced writer. Expected results come from the
// list of bytes offered in each burst.
module tb_fifo_readback_checker;

    localparam int         BL  = 300;   // above 256, so the expected value wraps
    localparam int         TMO = 16;
    localparam logic [7:0] SV  = 8'h00;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;
    logic [15:0] rd_count;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_data;

    fifo_readback_checker #(
        .DATA_W        (8),
        .BURST_LEN     (BL),
        .START_VALUE   (SV),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .start         (start),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .rd_count      (rd_count),
        .first_err_idx (first_err_idx),
        .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] burst_src[$];   // bytes offered for the current burst
    logic [7:0] fifo_q[$];      // FIFO contents
    logic [7:0] writer_q[$];    // bytes the writer has not pushed yet
    int         writer_gap  = 0;
    bit         writer_rand = 0;
    int         gap_cnt     = 0;

    int   n_rd, n_done, n_underflow, last_rd_cyc, done_cyc;
    logic rd_now;

    // Observe the DUT at the falling edge, away from the active edge.
    task automatic sample();
        @(negedge clk);
        rd_now = fifo_rd_en;
        if (rd_now === 1'b1) begin
            n_rd++;
            last_rd_cyc = cyc;
            if (fifo_q.size() == 0) n_underflow++;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    // Apply the FIFO read and write effects just after the rising edge.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rd_now === 1'b1 && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        if (writer_q.size() != 0) begin
            if (gap_cnt == 0) begin
                fifo_q.push_back(writer_q.pop_front());
                gap_cnt = writer_rand ? int'($urandom_range(writer_gap, 0)) : writer_gap;
            end else begin
                gap_cnt--;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic make_pattern(input int len);
        burst_src.delete();
        for (int i = 0; i < len; i++) burst_src.push_back(8'(SV + i));
    endtask

    task automatic load(input bit use_writer, input int gap, input bit rnd);
        fifo_q.delete();
        writer_q.delete();
        if (use_writer) writer_q = burst_src;
        else            fifo_q   = burst_src;
        writer_gap  = gap;
        writer_rand = rnd;
        gap_cnt     = 0;
        fifo_empty  = (fifo_q.size() == 0);
    endtask

    // Start one burst and check the results against the reference model.
    // mid_a / mid_b are cycle offsets from start at which start is pulsed
    // again (0 = unused).
    task automatic run_burst(input string name, input bit chk_lat,
                             input int mid_a, input int mid_b);
        int         s, budget, n_exp, err_exp, idx_exp;
        logic [7:0] data_exp;
        bit         tmo_exp, pass_exp;
        n_exp    = (burst_src.size() < BL) ? burst_src.size() : BL;
        tmo_exp  = (burst_src.size() < BL);
        err_exp  = 0;
        idx_exp  = 0;
        data_exp = 8'h00;
        for (int i = 0; i < n_exp; i++) begin
            if (burst_src[i] !== 8'(SV + i)) begin
                if (err_exp == 0) begin
                    idx_exp  = i;
                    data_exp = burst_src[i];
                end
                err_exp++;
            end
        end
        pass_exp = (err_exp == 0) && !tmo_exp;

        n_rd = 0; n_done = 0; n_underflow = 0; last_rd_cyc = -1; done_cyc = -1;
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        total++;
        if (busy !== 1'b1 || rd_count !== 16'd0 || err_count !== 16'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s_cleared_on_start: busy=%b rd=%0d err=%0d tmo=%b want 1/0/0/0",
                     name, busy, rd_count, err_count, timeout);
        end
        advance();

        budget = 4000;
        while (n_done == 0 && budget > 0) begin
            start = (mid_a > 0 && cyc == s + mid_a) || (mid_b > 0 && cyc == s + mid_b);
            sample();
            if (n_done == 1) begin
                total++;
                if (rd_count !== 16'(n_exp)) begin
                    bad++;
                    $display("FAIL %s_rd_count: got=%0d want=%0d", name, rd_count, n_exp);
                end
                total++;
                if (err_count !== 16'(err_exp)) begin
                    bad++;
                    $display("FAIL %s_err_count: got=%0d want=%0d", name, err_count, err_exp);
                end
                total++;
                if (first_err_idx !== 16'(idx_exp) || first_err_data !== data_exp) begin
                    bad++;
                    $display("FAIL %s_first_err: got=%0d/%h want=%0d/%h",
                             name, first_err_idx, first_err_data, idx_exp, data_exp);
                end
                total++;
                if (timeout !== tmo_exp) begin
                    bad++;
                    $display("FAIL %s_timeout: got=%b want=%b", name, timeout, tmo_exp);
                end
            end
            advance();
            budget--;
        end
        start = 1'b0;
        total++;
        if (n_done == 0) begin
            bad++;
            $display("FAIL %s_done_seen: got=no done want=done within budget", name);
        end

        sample();
        total++;
        if (pass !== pass_exp || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_pass: got pass=%b busy=%b want pass=%b busy=0", name, pass, busy, pass_exp);
        end
        advance();
        repeat (3) tick();

        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL %s_done_count: got=%0d want=1", name, n_done);
        end
        total++;
        if (n_rd != n_exp || n_underflow != 0) begin
            bad++;
            $display("FAIL %s_reads: got=%0d underflow=%0d want=%0d underflow=0",
                     name, n_rd, n_underflow, n_exp);
        end
        if (chk_lat) begin
            total++;
            if (done_cyc - s != BL + 2) begin
                bad++;
                $display("FAIL %s_latency: got=%0d want=%0d", name, done_cyc - s, BL + 2);
            end
        end
        if (tmo_exp) begin
            // TMO empty cycles after the last read, then the REPORT cycle.
            total++;
            if (done_cyc - last_rd_cyc != TMO + 1) begin
                bad++;
                $display("FAIL %s_timeout_latency: got=%0d want=%0d",
                         name, done_cyc - last_rd_cyc, TMO + 1);
            end
        end
    endtask

    task automatic test_reset();
        make_pattern(BL);
        load(1'b0, 0, 1'b0);
        srst  = 1'b1;
        start = 1'b1;   // start and srst together: srst wins
        repeat (3) tick();
        sample();
        total++;
        if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b rd_en=%b done=%b want 0/0/0", busy, fifo_rd_en, done);
        end
        total++;
        if (pass !== 1'b0 || timeout !== 1'b0 || err_count !== 16'd0 || rd_count !== 16'd0 ||
            first_err_idx !== 16'd0 || first_err_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_results: pass=%b tmo=%b err=%0d rd=%0d idx=%0d data=%h want all 0",
                     pass, timeout, err_count, rd_count, first_err_idx, first_err_data);
        end
        advance();
        srst  = 1'b0;
        start = 1'b0;
        n_rd  = 0;
        repeat (3) tick();
        sample();
        total++;
        if (busy !== 1'b0 || n_rd != 0) begin
            bad++;
            $display("FAIL reset_start_ignored: busy=%b reads=%0d want 0/0", busy, n_rd);
        end
        advance();
    endtask

    task automatic test_clean_burst();
        make_pattern(BL);
        load(1'b0, 0, 1'b0);
        run_burst("clean", 1'b1, 0, 0);
    endtask

    task automatic test_single_error();
        make_pattern(BL);
        burst_src[17] = 8'hAA;
        load(1'b0, 0, 1'b0);
        run_burst("byte17", 1'b1, 0, 0);
    endtask

    task automatic test_slow_writer();
        make_pattern(BL);
        load(1'b1, 3, 1'b0);   // one byte every 4 cycles
        run_burst("slow_writer", 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            make_pattern(BL);
            for (int i = 0; i < BL; i++) begin
                if ($urandom_range(15, 0) == 0) burst_src[i] = 8'($urandom);
            end
            load(1'b1, 3, 1'b1);
            run_burst($sformatf("random%0d", k), 1'b0, 0, 0);
        end
    endtask

    task automatic test_timeout();
        make_pattern(10);
        load(1'b0, 0, 1'b0);
        run_burst("timeout", 1'b0, 0, 0);
    endtask

    task automatic test_srst_mid();
        int budget;
        make_pattern(BL);
        load(1'b0, 0, 1'b0);
        n_rd = 0; n_done = 0; n_underflow = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        budget = 1000;
        while (n_rd < 100 && budget > 0) begin
            tick();
            budget--;
        end
        total++;
        if (n_rd != 100) begin
            bad++;
            $display("FAIL srst_reach_byte100: got=%0d want=100", n_rd);
        end
        srst = 1'b1;
        sample();
        total++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL srst_cycle: rd_en=%b busy=%b want 0/0", fifo_rd_en, busy);
        end
        advance();
        srst = 1'b0;
        repeat (20) tick();
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL srst_no_done: got=%0d want=0", n_done);
        end
        sample();
        total++;
        if (busy !== 1'b0 || rd_count !== 16'd0 || err_count !== 16'd0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL srst_cleared: busy=%b rd=%0d err=%0d tmo=%b want 0/0/0/0",
                     busy, rd_count, err_count, timeout);
        end
        advance();
        // The FIFO is reset alongside the checker before the next burst.
        make_pattern(BL);
        load(1'b0, 0, 1'b0);
        run_burst("after_srst", 1'b1, 0, 0);
    endtask

    task automatic test_restart_ignored();
        make_pattern(BL);
        load(1'b0, 0, 1'b0);
        run_burst("restart_ignored", 1'b1, 50, BL + 2);   // mid-burst and in REPORT
    endtask

    initial begin
        srst       = 1'b1;
        start      = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        test_reset();
        test_clean_burst();
        test_single_error();
        test_slow_writer();
        test_random();
        test_timeout();
        test_srst_mid();
        test_restart_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
